// File: rtl/riscv_pkg.sv
// Shared definitions for the data-memory responder.
//   - RV32I load/store width codes (funct3)
//   - FSM state enum for dmem_responder
//   - access_fault(): flags illegal width codes and misaligned accesses
package riscv_pkg;

  // RV32I funct3 width codes (stores use only the first three)
  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } dmem_state_e;

  // Illegal funct3 for the access direction, or address not aligned to the
  // access size. Range checking is left to the caller (depends on depth).
  function automatic logic access_fault(input logic       we,
                                        input logic [2:0] funct3,
                                        input logic [1:0] byte_off);
    logic f;
    f = 1'b0;
    if (we) begin
      case (funct3)
        F3_B:    f = 1'b0;
        F3_H:    f = byte_off[0];
        F3_W:    f = |byte_off;
        default: f = 1'b1;
      endcase
    end else begin
      case (funct3)
        F3_B, F3_BU: f = 1'b0;
        F3_H, F3_HU: f = byte_off[0];
        F3_W:        f = |byte_off;
        default:     f = 1'b1;
      endcase
    end
    return f;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane steering for a 32-bit data memory word.
//   i_funct3     : RV32I width code
//   i_byte_off   : addr[1:0] of the access
//   i_word       : current contents of the addressed memory word
//   i_wdata      : right-aligned store data
//   o_load_data  : selected byte/half/word, sign- or zero-extended
//   o_store_word : i_word with the store lanes replaced by i_wdata
// Illegal codes yield o_load_data=0 and o_store_word=i_word; the caller is
// expected to block errored accesses anyway.
module dmem_lane_align
  import riscv_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_byte_off,
  input  logic [31:0] i_word,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_load_data,
  output logic [31:0] o_store_word
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [3:0]  w_lane_en;
  logic [31:0] w_wdata_rep;

  assign w_byte = i_word[{i_byte_off, 3'b000} +: 8];
  assign w_half = i_word[{i_byte_off[1], 4'b0000} +: 16];

  always_comb begin
    o_load_data = '0;
    case (i_funct3)
      F3_B:    o_load_data = {{24{w_byte[7]}}, w_byte};
      F3_BU:   o_load_data = {24'd0, w_byte};
      F3_H:    o_load_data = {{16{w_half[15]}}, w_half};
      F3_HU:   o_load_data = {16'd0, w_half};
      F3_W:    o_load_data = i_word;
      default: o_load_data = '0;
    endcase
  end

  // Store data is replicated across lanes so each lane can pick its own copy
  always_comb begin
    w_lane_en   = 4'b0000;
    w_wdata_rep = i_wdata;
    case (i_funct3)
      F3_B: begin
        w_lane_en   = 4'b0001 << i_byte_off;
        w_wdata_rep = {4{i_wdata[7:0]}};
      end
      F3_H: begin
        w_lane_en   = i_byte_off[1] ? 4'b1100 : 4'b0011;
        w_wdata_rep = {2{i_wdata[15:0]}};
      end
      F3_W: begin
        w_lane_en   = 4'b1111;
        w_wdata_rep = i_wdata;
      end
      default: begin
        w_lane_en   = 4'b0000;
        w_wdata_rep = i_wdata;
      end
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign o_store_word[8*gi +: 8] = w_lane_en[gi] ? w_wdata_rep[8*gi +: 8]
                                                     : i_word[8*gi +: 8];
    end
  endgenerate

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for an RV32I MEM stage.
// One request at a time: accept in IDLE, wait LATENCY cycles, present the
// response in RESP until the consumer takes it.
//   clk, reset_n                  : clock, async active-low reset
//   req_valid/req_ready           : request handshake (ready only in IDLE)
//   req_we, req_addr, req_funct3  : store flag, byte address, width code
//   req_wdata                     : right-aligned store data
//   resp_valid/resp_ready         : response handshake
//   resp_rdata, resp_err          : extended load data / error flag
//   busy                          : FSM not in IDLE
module dmem_responder
  import riscv_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        busy
);

  localparam int AW = $clog2(DEPTH_WORDS);

  logic [31:0] r_mem [DEPTH_WORDS];

  dmem_state_e r_state, w_state_next;
  logic [3:0]  r_cnt, w_cnt_next;
  logic        r_ready_en;   // low during reset and until the first edge after it
  logic [31:0] r_rdata;
  logic        r_err;

  logic          w_accept;
  logic [AW-1:0] w_idx;
  logic          w_range_err;
  logic          w_err;
  logic [31:0]   w_word;
  logic [31:0]   w_load_data;
  logic [31:0]   w_store_word;
  logic [31:0]   w_rdata_cap;

  assign w_idx       = req_addr[AW+1:2];
  assign w_range_err = (req_addr >> (AW + 2)) != 32'd0;
  assign w_err       = w_range_err | access_fault(req_we, req_funct3, req_addr[1:0]);
  assign w_word      = r_mem[w_idx];
  // Decoded from registers only, so the FSM block does not loop through req_ready
  assign w_accept    = req_valid & r_ready_en & (r_state == ST_IDLE);
  assign w_rdata_cap = (w_err | req_we) ? 32'd0 : w_load_data;

  dmem_lane_align u_align (
    .i_funct3     (req_funct3),
    .i_byte_off   (req_addr[1:0]),
    .i_word       (w_word),
    .i_wdata      (req_wdata),
    .o_load_data  (w_load_data),
    .o_store_word (w_store_word)
  );

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    req_ready    = 1'b0;
    resp_valid   = 1'b0;
    busy         = 1'b1;
    case (r_state)
      ST_IDLE: begin
        busy      = 1'b0;
        req_ready = r_ready_en;
        if (w_accept) begin
          if (LATENCY == 1) begin
            w_state_next = ST_RESP;
          end else begin
            w_state_next = ST_WAIT;
            w_cnt_next   = 4'(LATENCY - 1);
          end
        end
      end
      ST_WAIT: begin
        if (r_cnt <= 4'd1) begin
          w_state_next = ST_RESP;
          w_cnt_next   = 4'd0;
        end else begin
          w_cnt_next = r_cnt - 4'd1;
        end
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) begin
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
        w_cnt_next   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_cnt      <= 4'd0;
      r_ready_en <= 1'b0;
      r_rdata    <= 32'd0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_cnt      <= w_cnt_next;
      r_ready_en <= 1'b1;
      if (w_accept) begin
        r_rdata <= w_rdata_cap;
        r_err   <= w_err;
      end
    end
  end

  assign resp_rdata = r_rdata;
  assign resp_err   = r_err;

  // Storage is never reset; a store commits on its accept edge
  always_ff @(posedge clk) begin
    if (w_accept && req_we && !w_err) begin
      r_mem[w_idx] <= w_store_word;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

  localparam int DEPTH = 256;
  localparam int LAT   = 2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [2:0]  req_funct3;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        busy;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_funct3 (req_funct3),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;
  int n_req = 0;
  int hold_left = 0;

  typedef struct {
    int          acc_cyc;
    logic [31:0] rdata;
    logic        err;
  } exp_t;
  exp_t exp_q[$];

  // Byte-addressed reference memory
  logic [7:0] mb [0:4*DEPTH-1];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Reference: access of 'size' bytes at 'a', little-endian
  function automatic void model(input logic we, input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] wd, output logic [31:0] rd, output logic err);
    int size;
    logic legal;
    logic [31:0] v;
    legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    size  = 1 << f3[1:0];
    err   = !legal || ((a % size) != 0) || ((a / 4) >= DEPTH);
    rd    = 32'd0;
    if (!err) begin
      if (we) begin
        for (int i = 0; i < size; i++) mb[a + i] = wd[8*i +: 8];
      end else begin
        v = 32'd0;
        for (int i = 0; i < size; i++) v[8*i +: 8] = mb[a + i];
        if (!f3[2] && size < 4 && v[8*size-1])
          for (int i = 8*size; i < 32; i++) v[i] = 1'b1;
        rd = v;
      end
    end
  endfunction

  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd);
    exp_t e;
    int guard;
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    guard = 0;
    while (!req_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!req_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL accept_timeout: req_ready stayed %0b, expected 1", req_ready);
      req_valid = 1'b0;
      return;
    end
    model(we, f3, a, wd, e.rdata, e.err);
    e.acc_cyc = cyc;
    exp_q.push_back(e);
    n_req++;
    $display("req %0d: we=%0b f3=%0d addr=%h wdata=%h -> exp rdata=%h err=%0b",
             n_req, we, f3, a, wd, e.rdata, e.err);
    @(posedge clk);
    #1;
    // Garbage on the bus outside the accept edge must be ignored
    req_valid  = 1'b0;
    req_we     = 1'($urandom);
    req_funct3 = 3'($urandom);
    req_addr   = $urandom;
    req_wdata  = $urandom;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 300) begin
      @(negedge clk);
      g++;
    end
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: %0d responses outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // Monitor / scoreboard
  logic        seen = 1'b0;
  logic        have_cur = 1'b0;
  logic        just_consumed = 1'b0;
  logic [31:0] held_rd;
  logic        held_err;
  exp_t        cur;

  always @(negedge clk) begin
    if (!reset_n) begin
      seen          = 1'b0;
      have_cur      = 1'b0;
      just_consumed = 1'b0;
      resp_ready    = 1'b0;
    end else begin
      if (just_consumed) begin
        chk("ready_after_consume", 32'(req_ready), 32'd1);
        just_consumed = 1'b0;
      end
      if (resp_valid) begin
        chk("ready_low_in_resp", 32'(req_ready), 32'd0);
        chk("busy_in_resp", 32'(busy), 32'd1);
        if (!seen) begin
          seen = 1'b1;
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            have_cur = 1'b0;
            $display("FAIL unexpected_resp: rdata=%h err=%0b with no request outstanding",
                     resp_rdata, resp_err);
          end else begin
            cur = exp_q.pop_front();
            have_cur = 1'b1;
            chk("latency", 32'(cyc - cur.acc_cyc), 32'(LAT));
            chk("rdata", resp_rdata, cur.rdata);
            chk("err", 32'(resp_err), 32'(cur.err));
            $display("resp: rdata=%h err=%0b latency=%0d", resp_rdata, resp_err, cyc - cur.acc_cyc);
          end
          held_rd  = resp_rdata;
          held_err = resp_err;
        end else begin
          chk("hold_rdata", resp_rdata, held_rd);
          chk("hold_err", 32'(resp_err), 32'(held_err));
        end
        if (hold_left > 0) begin
          resp_ready = 1'b0;
          hold_left--;
        end else begin
          resp_ready = ($urandom_range(0, 3) != 0);
        end
        if (resp_ready) begin
          seen = 1'b0;
          just_consumed = 1'b1;
        end
      end else begin
        resp_ready = 1'b0;
      end
    end
  end

  initial begin
    reset_n    = 1'b0;
    resp_ready = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_addr   = 32'd0;
    req_funct3 = 3'd0;
    req_wdata  = 32'd0;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    chk("rst_err", 32'(resp_err), 32'd0);
    reset_n = 1'b1;
    #1;
    chk("ready_before_first_edge", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1;
    chk("ready_after_first_edge", 32'(req_ready), 32'd1);

    // Initialise the words the random phase uses
    for (int i = 0; i < 64; i++) issue(1'b1, 3'd2, 32'(4 * i), $urandom);
    drain();

    // Word store / load round trip
    issue(1'b1, 3'd2, 32'h10, 32'hDEADBEEF);
    issue(1'b0, 3'd2, 32'h10, 32'h0);
    // Byte store, signed/unsigned byte and half loads
    issue(1'b1, 3'd0, 32'h13, 32'h80);
    issue(1'b0, 3'd0, 32'h13, 32'h0);
    issue(1'b0, 3'd4, 32'h13, 32'h0);
    issue(1'b0, 3'd1, 32'h12, 32'h0);
    // Misaligned accesses leave the word intact
    issue(1'b0, 3'd2, 32'h12, 32'h0);
    issue(1'b1, 3'd1, 32'h11, 32'hFFFF);
    issue(1'b0, 3'd2, 32'h10, 32'h0);
    // Out of range and illegal funct3
    issue(1'b0, 3'd2, 32'h400, 32'h0);
    issue(1'b0, 3'd3, 32'h10, 32'h0);
    drain();

    // Back-pressure: five cycles of resp_ready=0, then immediate re-accept
    hold_left = 5;
    issue(1'b0, 3'd2, 32'h10, 32'h0);
    issue(1'b0, 3'd0, 32'h11, 32'h0);
    drain();

    // Reset during WAIT: response dropped, store stays committed
    issue(1'b1, 3'd2, 32'h20, 32'h1234);
    reset_n = 1'b0;
    #1;
    chk("midrst_resp_valid", 32'(resp_valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_req_ready", 32'(req_ready), 32'd0);
    chk("midrst_rdata", resp_rdata, 32'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("midrst_ready_before_edge", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1;
    chk("midrst_ready_after_edge", 32'(req_ready), 32'd1);
    issue(1'b0, 3'd2, 32'h20, 32'h0);
    drain();

    // Randomised traffic
    for (int n = 0; n < 300; n++) begin
      logic        we;
      logic [2:0]  f3;
      logic [31:0] a;
      we = 1'($urandom);
      f3 = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 15) == 0) a = 32'h400 + 32'($urandom_range(0, 4095));
      else a = 32'($urandom_range(0, 255));
      issue(we, f3, a, $urandom);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 256: word-addressed storage depth, power of two.
REQ-002 SHALL have parameter LATENCY, default 2, legal range 1..15: cycles from request accept to first resp_valid.
REQ-003 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_n, input, 1: reset, asynchronous and active-low.
REQ-005 SHALL have port req_valid, input, 1: the MEM stage presents a request.
REQ-006 SHALL have port req_ready, output, 1: the block can accept a request this cycle.
REQ-007 SHALL have port req_we, input, 1: 1 = store, 0 = load.
REQ-008 SHALL have port req_addr, input, 32: byte address.
REQ-009 SHALL have port req_funct3, input, 3: RV32I width code (LB=0, LH=1, LW=2, LBU=4, LHU=5; SB=0, SH=1, SW=2).
REQ-010 SHALL have port req_wdata, input, 32: store data, right-aligned.
REQ-011 SHALL have port resp_valid, output, 1: a response is presented.
REQ-012 SHALL have port resp_ready, input, 1: the MEM stage takes the response.
REQ-013 SHALL have port resp_rdata, output, 32: load result, extended to 32 bits; 0 for stores and errors.
REQ-014 SHALL have port resp_err, output, 1: the request was misaligned, out of range, or used an illegal funct3.
REQ-015 SHALL have port busy, output, 1: high whenever the FSM is not IDLE.

Function
REQ-016 SHALL implement a 3-state FSM: IDLE, WAIT, RESP.
REQ-017 SHALL drive req_ready=1 only in IDLE; a request is accepted on a clock edge where req_valid && req_ready.
REQ-018 SHALL, on accept, capture the response and commit any store on that same edge; the FSM then goes to WAIT, or to RESP directly if LATENCY=1.
REQ-019 SHALL count WAIT cycles with a down-counter so that resp_valid rises exactly LATENCY cycles after the accept edge.
REQ-020 SHALL hold resp_valid, resp_rdata and resp_err stable in RESP until an edge where resp_ready=1, then return to IDLE.
REQ-021 SHALL NOT accept a new request in the cycle the response is consumed; back-to-back throughput is one request per LATENCY+1 cycles minimum.
REQ-022 SHALL sign-extend LB/LH loads and zero-extend LBU/LHU loads, selecting the byte or half by addr[1:0].
REQ-023 SHALL perform stores as a byte-lane merge: SB writes the lane at addr[1:0], SH writes lanes {addr[1],0}..+1, SW writes all four lanes.
REQ-024 SHALL flag as errors: LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0; word index >= DEPTH_WORDS; load funct3 of 3, 6 or 7; store funct3 > 2.
REQ-025 SHALL, for an errored request, leave memory unmodified and return resp_err=1 with resp_rdata=0, using the same latency as a good request.
REQ-026 SHALL, for a store, respond with resp_rdata=0 and resp_err=0.
REQ-027 SHALL ignore req_* inputs outside the accept edge.

Reset
REQ-028 SHALL, while reset_n=0, force state=IDLE, counter=0, resp_valid=0, resp_rdata=0, resp_err=0, busy=0 and req_ready=0.
REQ-029 SHALL drive req_ready=1 from the first edge after reset_n deasserts.
REQ-030 SHALL, on reset mid-operation, drop the pending response; a store accepted before reset stays committed.
REQ-031 SHALL NOT reset memory contents.

Structure
REQ-032 SHALL place the funct3 width codes and the FSM state enum in the shared package riscv_pkg.
REQ-033 SHALL implement load extraction/extension and store lane merge in one combinational sub-module, dmem_lane_align.
REQ-034 SHALL hold storage in a 32-bit word array, indexed by req_addr[log2(DEPTH_WORDS)+1:2].

Verification
REQ-035 SHALL cover: SW 0xDEADBEEF @0x10, then LW @0x10 -> resp_rdata=0xDEADBEEF, resp_err=0, resp_valid exactly 2 cycles after each accept.
REQ-036 SHALL cover: SB 0x80 @0x13, then LB @0x13 -> 0xFFFFFF80; LBU @0x13 -> 0x00000080; LH @0x12 -> 0xFFFF80AD.
REQ-037 SHALL cover: LW @0x12 and SH @0x11 -> resp_err=1, resp_rdata=0, and the word at 0x10 is unchanged.
REQ-038 SHALL cover: LW @0x400 with DEPTH_WORDS=256 -> resp_err=1; LW with funct3=3 -> resp_err=1.
REQ-039 SHALL cover: hold resp_ready=0 for 5 cycles -> resp_valid and resp_rdata stay stable and req_ready=0 throughout; the block accepts again 1 cycle after consume.
REQ-040 SHALL cover: SW 0x1234 then assert reset_n=0 during WAIT -> resp_valid=0 at once; after release, LW returns 0x1234.
